// File: rtl/mm_pkg.sv
// Shared constants for the mm_* data-memory interface: peripheral addresses,
// store-length encodings and the serial transmitter state type.
package mm_pkg;

  localparam logic [63:0] RTC_ADDR         = 64'hA000_0048;
  localparam logic [63:0] SERIAL_DATA_ADDR = 64'hA000_03F8;
  localparam logic [63:0] SERIAL_STAT_ADDR = 64'hA000_03FC;

  localparam logic [3:0] WLEN_B = 4'd1;
  localparam logic [3:0] WLEN_H = 4'd2;
  localparam logic [3:0] WLEN_W = 4'd4;
  localparam logic [3:0] WLEN_D = 4'd8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  function automatic logic wlen_legal(input logic [3:0] wlen);
    return (wlen == WLEN_B) || (wlen == WLEN_H) || (wlen == WLEN_W) || (wlen == WLEN_D);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 serial transmitter; a new frame starts on the same
// edge the byte is popped, so queued bytes go out back to back.
//   state    | meaning
//   TX_IDLE  | line high, waiting for the FIFO to go non-empty
//   TX_START | start bit (0) for BAUD_DIV cycles
//   TX_DATA  | eight data bits, LSB first, BAUD_DIV cycles each
//   TX_STOP  | stop bit (1); chains straight into TX_START if more data queued
module uart_tx_fifo
  import mm_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_DIV   = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       clr_ovf,
  output logic       full,
  output logic       busy,
  output logic       ovf,
  output logic       uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic          baud_tc;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  tx_state_t     state;
  tx_state_t     state_nxt;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign baud_tc = (baud_cnt == '0);
  assign pop     = !empty && ((state == TX_IDLE) || ((state == TX_STOP) && baud_tc));
  // a pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign push_ok = push && (!full || pop);
  assign busy    = !empty || (state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: ;
      endcase
      if (clr_ovf)           ovf <= 1'b0;
      if (push && !push_ok)  ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= TX_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:  if (!empty) state_nxt = TX_START;
      TX_START: if (baud_tc) state_nxt = TX_DATA;
      TX_DATA:  if (baud_tc && (bit_cnt == 3'd0)) state_nxt = TX_STOP;
      TX_STOP:  if (baud_tc) state_nxt = empty ? TX_IDLE : TX_START;
      default:  state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    case (state)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = shreg[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (pop) begin
      baud_cnt <= BAUD_LAST;
      bit_cnt  <= 3'd7;
      shreg    <= fifo_mem[rd_ptr];
    end else if (state != TX_IDLE) begin
      if (baud_tc) begin
        baud_cnt <= BAUD_LAST;
        if (state == TX_DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_cnt <= bit_cnt - 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - BW'(1);
      end
    end
  end

endmodule

// File: rtl/mm_responder.sv
// Target side of the mm_* data-memory interface: decodes each access to the
// data RAM, the microsecond RTC or the serial TX port.
module mm_responder
  import mm_pkg::*;
#(
  parameter logic [63:0] RAM_BASE   = 64'h8000_0000,
  parameter int          RAM_WORDS  = 4096,
  parameter int          FIFO_DEPTH = 16,
  parameter int          BAUD_DIV   = 16,
  parameter int          CLK_PER_US = 100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] mm_addr,
  input  logic [63:0] mm_wdata,
  input  logic [3:0]  mm_wlen,
  input  logic        mm_wen,
  input  logic        mm_ren,
  output logic [63:0] mm_rdata,
  output logic        uart_tx,
  output logic        bus_err
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam logic [63:0] RAM_END = RAM_BASE + 64'(RAM_WORDS) * 64'd8;
  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);

  logic [2:0]        lane;
  logic [4:0]        lane_end;
  logic              in_ram;
  logic              is_rtc;
  logic              is_ser;
  logic              mapped;
  logic              size_ok;
  logic              wr_ok;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        byte_en;
  logic [63:0]       wdata_sh;
  logic [63:0]       ram_mem [RAM_WORDS];
  logic [63:0]       rtc;
  logic [PW-1:0]     presc;
  logic              ser_push;
  logic              ser_clr_ovf;
  logic              ser_full;
  logic              ser_busy;
  logic              ser_ovf;

  assign lane     = mm_addr[2:0];
  assign lane_end = {2'b00, lane} + {1'b0, mm_wlen};
  assign in_ram   = (mm_addr >= RAM_BASE) && (mm_addr < RAM_END);
  assign is_rtc   = (mm_addr[63:3] == RTC_ADDR[63:3]);
  assign is_ser   = (mm_addr[63:3] == SERIAL_DATA_ADDR[63:3]);
  assign mapped   = in_ram || is_rtc || is_ser;
  assign size_ok  = wlen_legal(mm_wlen) && (lane_end <= 5'd8);
  assign wr_ok    = mm_wen && mapped && size_ok;
  assign ram_we   = wr_ok && in_ram;
  assign ram_idx  = RAM_AW'((mm_addr - RAM_BASE) >> 3);
  assign wdata_sh = mm_wdata << {lane, 3'b000};

  // The data byte is lane 0 of the serial doubleword, the status word lanes 4..7.
  assign ser_push    = wr_ok && is_ser && (lane == SERIAL_DATA_ADDR[2:0]);
  assign ser_clr_ovf = wr_ok && is_ser && (lane_end > {2'b00, SERIAL_STAT_ADDR[2:0]});

  always_comb begin
    byte_en = '0;
    for (int i = 0; i < 8; i++) begin
      byte_en[i] = (5'(i) >= {2'b00, lane}) && (5'(i) < lane_end);
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 8; i++) begin
        if (byte_en[i]) ram_mem[ram_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc <= '0;
      rtc   <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      rtc   <= rtc + 64'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_err <= 1'b0;
    end else if ((mm_wen && !(mapped && size_ok)) || (mm_ren && !mapped)) begin
      bus_err <= 1'b1;
    end
  end

  always_comb begin
    mm_rdata = '0;
    if (mm_ren) begin
      if (in_ram)      mm_rdata = ram_mem[ram_idx];
      else if (is_rtc) mm_rdata = rtc;
      else if (is_ser) mm_rdata = {29'd0, ser_ovf, ser_busy, ser_full, 32'd0};
    end
  end

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_DIV   (BAUD_DIV)
  ) u_uart_tx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (ser_push),
    .push_data (mm_wdata[7:0]),
    .clr_ovf   (ser_clr_ovf),
    .full      (ser_full),
    .busy      (ser_busy),
    .ovf       (ser_ovf),
    .uart_tx   (uart_tx)
  );

endmodule

// File: tb/tb_mm_responder.sv
// Randomized and directed bench for mm_responder against a behavioural model
// of the address map, byte-lane stores, RTC and serial framing.
module tb_mm_responder;

  localparam logic [63:0] RAM_BASE   = 64'h8000_0000;
  localparam int          RAM_WORDS  = 256;
  localparam int          FIFO_DEPTH = 4;
  localparam int          BAUD_DIV   = 4;
  localparam int          CLK_PER_US = 4;
  localparam int          FRAME      = 10 * BAUD_DIV;
  localparam logic [63:0] A_RTC      = 64'hA000_0048;
  localparam logic [63:0] A_SDATA    = 64'hA000_03F8;
  localparam logic [63:0] A_SSTAT    = 64'hA000_03FC;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] mm_addr;
  logic [63:0] mm_wdata;
  logic [3:0]  mm_wlen;
  logic        mm_wen;
  logic        mm_ren;
  logic [63:0] mm_rdata;
  logic        uart_tx;
  logic        bus_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc;
  logic        exp_err;
  logic [63:0] ram_m [int];

  mm_responder #(
    .RAM_BASE   (RAM_BASE),
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_DIV   (BAUD_DIV),
    .CLK_PER_US (CLK_PER_US)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .mm_addr  (mm_addr),
    .mm_wdata (mm_wdata),
    .mm_wlen  (mm_wlen),
    .mm_wen   (mm_wen),
    .mm_ren   (mm_ren),
    .mm_rdata (mm_rdata),
    .uart_tx  (uart_tx),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  // time base for the RTC model: clock edges since reset release
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic in_ram_addr(input logic [63:0] a);
    return (a >= RAM_BASE) && (a < RAM_BASE + 64'(8 * RAM_WORDS));
  endfunction

  function automatic logic mapped_addr(input logic [63:0] a);
    return in_ram_addr(a) || ((a & ~64'h7) == A_RTC) || ((a & ~64'h7) == A_SDATA);
  endfunction

  function automatic logic legal_store(input logic [2:0] off, input logic [3:0] len);
    return ((len == 4'd1) || (len == 4'd2) || (len == 4'd4) || (len == 4'd8))
           && (int'(off) + int'(len) <= 8);
  endfunction

  // line level at cycle c of an 8N1 frame carrying byte b
  function automatic logic frame_bit(input logic [7:0] b, input int c);
    int slot;
    slot = c / BAUD_DIV;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic model_store(input logic [63:0] a, input logic [63:0] d, input logic [3:0] len);
    int idx;
    int off;
    logic [63:0] w;
    if (!mapped_addr(a) || !legal_store(a[2:0], len)) begin
      exp_err = 1'b1;
    end else if (in_ram_addr(a)) begin
      idx = int'((a - RAM_BASE) >> 3);
      off = int'(a[2:0]);
      w = ram_m.exists(idx) ? ram_m[idx] : 64'hx;
      for (int i = 0; i < int'(len); i++) w[8*(off+i) +: 8] = d[8*i +: 8];
      ram_m[idx] = w;
    end
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [3:0] len);
    mm_addr  = a;
    mm_wdata = d;
    mm_wlen  = len;
    mm_wen   = 1'b1;
    @(negedge clk);
    mm_wen   = 1'b0;
    model_store(a, d, len);
  endtask

  task automatic do_read(input logic [63:0] a, output logic [63:0] v);
    mm_addr = a;
    mm_ren  = 1'b1;
    #1 v = mm_rdata;
    @(negedge clk);
    mm_ren  = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [63:0] a);
    logic [63:0] v;
    logic [63:0] e;
    logic known;
    int idx;
    known = 1'b1;
    e = '0;
    mm_addr = a;
    mm_ren  = 1'b1;
    #1 v = mm_rdata;
    if (!mapped_addr(a)) begin
      exp_err = 1'b1;
    end else if (in_ram_addr(a)) begin
      idx = int'((a - RAM_BASE) >> 3);
      if (ram_m.exists(idx)) e = ram_m[idx];
      else known = 1'b0;
    end else begin
      e = 64'(cyc / CLK_PER_US);
    end
    if (known) check(tag, v, e);
    @(negedge clk);
    mm_ren = 1'b0;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    exp_err = 1'b0;
  endtask

  function automatic logic [63:0] unmapped_addr();
    case ($urandom_range(0, 3))
      0:       return RAM_BASE + 64'(8 * RAM_WORDS) + 64'($urandom_range(0, 63));
      1:       return RAM_BASE - 64'd1 - 64'($urandom_range(0, 63));
      2:       return 64'h1000 + 64'($urandom_range(0, 4095));
      default: return 64'hA000_0040 + 64'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic rand_op();
    int op;
    int idx;
    logic [63:0] d;
    logic [63:0] base;
    logic [3:0] len;
    logic [2:0] off;
    op   = $urandom_range(0, 19);
    idx  = ($urandom_range(0, 9) == 0) ? RAM_WORDS - 1 : $urandom_range(0, 31);
    base = RAM_BASE + 64'(idx * 8);
    d    = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       len = 4'd1;
      1:       len = 4'd2;
      2:       len = 4'd4;
      default: len = 4'd8;
    endcase
    off = 3'($urandom_range(0, 8 - int'(len)));
    if (op <= 7) begin
      do_write(base + 64'(off), d, len);
    end else if (op <= 13) begin
      read_check("ram_rd", base + 64'($urandom_range(0, 7)));
    end else if (op == 14) begin
      read_check("rtc_rd", A_RTC + 64'($urandom_range(0, 7)));
    end else if (op == 15) begin
      do_write(A_RTC + 64'(off), d, len);
    end else if (op == 16) begin
      do len = 4'($urandom_range(0, 15));
      while ((len == 4'd1) || (len == 4'd2) || (len == 4'd4) || (len == 4'd8));
      do_write(base, d, len);
    end else if (op == 17) begin
      if (len == 4'd1) len = 4'd8;
      off = 3'($urandom_range(9 - int'(len), 7));
      do_write(base + 64'(off), d, len);
    end else if (op == 18) begin
      read_check("unmapped_rd", unmapped_addr());
    end else begin
      do_write(unmapped_addr(), d, 4'd1);
    end
  endtask

  initial begin
    logic [63:0] v;
    logic [7:0]  b;
    logic [7:0]  bq [$];
    logic        e;

    rstn = 1'b0; mm_addr = '0; mm_wdata = '0; mm_wlen = '0;
    mm_wen = 1'b0; mm_ren = 1'b0; exp_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_rdata", mm_rdata, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    repeat (40) @(negedge clk);
    do_read(A_RTC, v);
    check("rtc_after_40", v, 64'd10);

    do_write(64'h8000_0010, 64'h1122_3344_5566_7788, 4'd8);
    do_read(64'h8000_0010, v);
    check("ram_dword", v, 64'h1122_3344_5566_7788);
    do_write(64'h8000_0013, 64'h0000_0000_0000_00AA, 4'd1);
    do_read(64'h8000_0010, v);
    check("ram_byte", v, 64'h1122_3344_AA66_7788);
    check("no_err_yet", bus_err, 1'b0);

    do_write(64'h8000_0000, 64'hCAFE_F00D_DEAD_BEEF, 4'd8);
    do_write(64'h8000_0006, 64'h0102_0304, 4'd4);
    do_read(64'h8000_0000, v);
    check("misalign_ram", v, 64'hCAFE_F00D_DEAD_BEEF);
    check("misalign_err", bus_err, 1'b1);
    do_read(64'h0000_1000, v);
    check("unmapped_rd", v, 64'd0);
    check("unmapped_err", bus_err, 1'b1);

    do_write(64'h8000_0018, 64'h0BAD_0BAD_0BAD_0BAD, 4'd8);
    mm_addr = 64'h8000_0018; mm_wdata = 64'h5555_AAAA_5555_AAAA; mm_wlen = 4'd8;
    mm_wen = 1'b1; mm_ren = 1'b1;
    #1 check("rw_old", mm_rdata, 64'h0BAD_0BAD_0BAD_0BAD);
    @(negedge clk);
    mm_wen = 1'b0;
    #1 check("rw_new", mm_rdata, 64'h5555_AAAA_5555_AAAA);
    mm_ren = 1'b0;
    model_store(64'h8000_0018, 64'h5555_AAAA_5555_AAAA, 4'd8);
    @(negedge clk);

    // single frame: start bit one cycle after the push edge
    do_write(A_SDATA, 64'h41, 4'd1);
    #1 check("tx_before_start", uart_tx, 1'b1);
    mm_addr = A_SSTAT; mm_ren = 1'b1;
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      #1;
      if (k < FRAME) check($sformatf("tx_0x41_c%0d", k), uart_tx, frame_bit(8'h41, k));
      if (k == FRAME - 1) check("stat_busy_end", mm_rdata, 64'h2_0000_0000);
      if (k == FRAME) begin
        check("stat_idle", mm_rdata, 64'd0);
        check("tx_idle", uart_tx, 1'b1);
      end
    end
    mm_ren = 1'b0;
    @(negedge clk);

    // overflow: six pushes on consecutive edges, the first is popped at once
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       do_write(A_SDATA, {$urandom, $urandom_range(0, 16777215), b}, 4'd1);
        1:       do_write(A_SDATA, {$urandom, $urandom_range(0, 16777215), b}, 4'd2);
        default: do_write(A_SDATA, {$urandom, $urandom_range(0, 16777215), b}, 4'd4);
      endcase
      if (i < 5) bq.push_back(b);
    end
    do_read(A_SSTAT, v);
    check("stat_ovf", v, 64'h7_0000_0000);
    do_write(A_SSTAT, {$urandom, $urandom}, 4'd4);
    do_read(A_SSTAT, v);
    check("stat_ovf_clr", v, 64'h3_0000_0000);
    mm_addr = A_SSTAT; mm_ren = 1'b1;
    for (int k = 7; k <= 5 * FRAME; k++) begin
      #1;
      if (k < 5 * FRAME) begin
        check($sformatf("tx_b2b_c%0d", k), uart_tx, frame_bit(bq[k / FRAME], k % FRAME));
      end else begin
        check("b2b_done_tx", uart_tx, 1'b1);
        check("b2b_done_stat", mm_rdata, 64'd0);
      end
      @(negedge clk);
    end
    mm_ren = 1'b0;

    // reset in the middle of a data byte of zeros
    do_write(A_SDATA, 64'h00, 4'd1);
    do_write(A_SDATA, 64'h5A, 4'd1);
    do_write(A_SDATA, 64'hC3, 4'd1);
    repeat (8) @(negedge clk);
    #1 check("tx_mid_data", uart_tx, 1'b0);
    rstn = 1'b0;
    #1 check("rst_async_tx", uart_tx, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    exp_err = 1'b0;
    mm_ren = 1'b1; mm_addr = A_SSTAT;
    #1 check("rst_fifo_empty", mm_rdata, 64'd0);
    mm_addr = A_RTC;
    #1 check("rst_rtc", mm_rdata, 64'd0);
    mm_ren = 1'b0;
    e = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1 e = e & uart_tx;
    end
    check("rst_no_frame", e, 1'b1);
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      pulse_reset();
      if (r == 0) begin
        for (int i = 0; i < 32; i++) do_write(RAM_BASE + 64'(8 * i), {$urandom, $urandom}, 4'd8);
        do_write(RAM_BASE + 64'(8 * (RAM_WORDS - 1)), {$urandom, $urandom}, 4'd8);
      end
      for (int n = 0; n < 60; n++) begin
        rand_op();
        check("bus_err", bus_err, exp_err);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
